rtc_bus_master: RTL and testbench

Parametrised multiplexed address/data bus master for the RTC chip. It replaces the fixed five-register date-write sequencer with a general transaction engine:
- A request FIFO accepts read or write transactions from the control logic.
- The engine drives the RTC's `ad`/`cs`/`wr`/`rd` strobes with programmable phase lengths.
- For reads, it returns the captured data on a response port.

The block sits between the date/time control FSMs and the RTC pins.

---
 rtl/rtc_bus_pkg.sv | 36 +++
 rtl/rtc_req_fifo.sv | 60 ++++++
 rtl/rtc_bus_master.sv | 214 +++++++++++++++++++++
 tb/tb_rtc_bus_master.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtc_bus_pkg: shared definitions for the RTC multiplexed-bus master.
//   rtc_state_t     - transaction engine phases (fixed 4-bit encoding)
//   DEF_T_*         - default phase lengths in clock cycles
//   RTC_*           - RTC register addresses used by the control FSMs
//   max2()          - elaboration-time helper for sizing the phase counter
package rtc_bus_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      ALE  = 4'd1,
      ACS  = 4'd2,
      AWR  = 4'd3,
      AREL = 4'd4,
      TURN = 4'd5,
      DCS  = 4'd6,
      DSTB = 4'd7,
      DREL = 4'd8,
      GAP  = 4'd9
   } rtc_state_t;

   localparam int unsigned DEF_T_ADDR = 5;
   localparam int unsigned DEF_T_TURN = 8;
   localparam int unsigned DEF_T_DATA = 5;
   localparam int unsigned DEF_T_GAP  = 9;

   localparam logic [7:0] RTC_DAY   = 8'h24;
   localparam logic [7:0] RTC_MONTH = 8'h25;
   localparam logic [7:0] RTC_YEAR  = 8'h26;
   localparam logic [7:0] RTC_CTRL  = 8'h00;
   localparam logic [7:0] RTC_XFER  = 8'hF1;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/rtc_req_fifo.sv
// rtc_req_fifo: synchronous request FIFO with flush.
//   clock, reset (async, active-low)
//   push/wdata : write side; ignored when full or when flush is high
//   pop/rdata  : read side; rdata shows the head entry combinationally
//   flush      : empties the FIFO on the next edge
//   full/empty : status from the registered occupancy count
module rtc_req_fifo #(
   parameter int unsigned WIDTH = 17,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   // A push coinciding with flush is discarded; a pop still hands the head
   // to the engine so the transaction it starts is not lost.
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/rtc_bus_master.sv
// rtc_bus_master: request-FIFO driven transaction engine for the RTC's
// multiplexed address/data bus.
//   clock, reset (async, active-low)
//   req_valid/req_ready/req_rnw/req_addr/req_wdata : request push port
//   flush      : discard queued (not yet started) requests
//   rsp_valid/rsp_rdata : read response (one-cycle pulse, data holds)
//   busy       : engine or pin sequence active, or requests queued
//   ad_out/ad_oe/ad_in  : bus drive value, drive enable, sampled value
//   ad, cs, wr, rd      : active-low RTC strobes
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned T_ADDR     = DEF_T_ADDR,
   parameter int unsigned T_TURN     = DEF_T_TURN,
   parameter int unsigned T_DATA     = DEF_T_DATA,
   parameter int unsigned T_GAP      = DEF_T_GAP
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rnw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              flush,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] ad_out,
   output logic              ad_oe,
   input  logic [DATA_W-1:0] ad_in,
   output logic              ad,
   output logic              cs,
   output logic              wr,
   output logic              rd
);

   // AREL needs a reload of 2, so the counter must hold at least 3.
   localparam int unsigned T_MAX = max2(max2(max2(T_ADDR, T_TURN), max2(T_DATA, T_GAP)), 3);
   localparam int unsigned CNT_W = $clog2(T_MAX + 1);
   localparam int unsigned REQ_W = 1 + ADDR_W + DATA_W;

   rtc_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              txn_rnw_q;
   logic [ADDR_W-1:0] txn_addr_q;
   logic [DATA_W-1:0] txn_wdata_q;

   logic [REQ_W-1:0]  fifo_rdata;
   logic              fifo_full, fifo_empty, pop;

   logic              ad_d, cs_d, wr_d, rd_d, oe_d, phase_d, phase_q;
   logic [ADDR_W-1:0] out_d;
   logic              capture;

   function automatic logic [CNT_W-1:0] reload(input rtc_state_t s);
      case (s)
         AWR:     return CNT_W'(T_ADDR - 1);
         AREL:    return CNT_W'(2);
         TURN:    return CNT_W'(T_TURN - 1);
         DSTB:    return CNT_W'(T_DATA - 1);
         DREL:    return CNT_W'(1);
         GAP:     return CNT_W'(T_GAP - 1);
         default: return '0;
      endcase
   endfunction

   function automatic rtc_state_t succ(input rtc_state_t s);
      case (s)
         ALE:     return ACS;
         ACS:     return AWR;
         AWR:     return AREL;
         AREL:    return TURN;
         TURN:    return DCS;
         DCS:     return DSTB;
         DSTB:    return DREL;
         DREL:    return GAP;
         default: return IDLE;
      endcase
   endfunction

   rtc_req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (req_valid),
      .pop   (pop),
      .flush (flush),
      .wdata ({req_rnw, req_addr, req_wdata}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign req_ready = ~fifo_full;
   assign pop       = (state_q == IDLE) & ~fifo_empty;
   // phase_q covers the extra cycle the registered pins lag the state.
   assign busy      = (state_q != IDLE) | ~fifo_empty | phase_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == IDLE) begin
         if (!fifo_empty) begin
            state_d = ALE;
            cnt_d   = reload(ALE);
         end
      end else if (cnt_q == '0) begin
         state_d = succ(state_q);
         cnt_d   = reload(succ(state_q));
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Pin values are decoded from the current state and registered, so every
   // pin changes one cycle after the state it belongs to.
   always_comb begin
      ad_d    = 1'b1;
      cs_d    = 1'b1;
      wr_d    = 1'b1;
      rd_d    = 1'b1;
      oe_d    = 1'b0;
      out_d   = '1;
      phase_d = (state_q != IDLE);
      case (state_q)
         ALE: ad_d = 1'b0;
         ACS: begin
            ad_d = 1'b0;
            cs_d = 1'b0;
         end
         AWR: begin
            ad_d  = 1'b0;
            cs_d  = 1'b0;
            wr_d  = 1'b0;
            oe_d  = 1'b1;
            out_d = txn_addr_q;
         end
         AREL: begin
            oe_d  = 1'b1;
            out_d = txn_addr_q;
            ad_d  = (cnt_q == '0);
            cs_d  = (cnt_q != CNT_W'(2));
         end
         TURN: oe_d = ~txn_rnw_q;
         DCS: begin
            cs_d = 1'b0;
            oe_d = ~txn_rnw_q;
         end
         DSTB: begin
            cs_d = 1'b0;
            if (txn_rnw_q) begin
               rd_d = 1'b0;
            end else begin
               wr_d  = 1'b0;
               oe_d  = 1'b1;
               out_d = ADDR_W'(txn_wdata_q);
            end
         end
         DREL: begin
            cs_d = (cnt_q == '0);
            // Write data is held through the release for hold time.
            if (!txn_rnw_q) begin
               oe_d  = 1'b1;
               out_d = ADDR_W'(txn_wdata_q);
            end
         end
         default: ;
      endcase
   end

   // First DREL state cycle is the last DSTB cycle on the pins.
   assign capture = txn_rnw_q & (state_q == DREL) & (cnt_q == CNT_W'(1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         txn_rnw_q   <= 1'b0;
         txn_addr_q  <= '0;
         txn_wdata_q <= '0;
         ad          <= 1'b1;
         cs          <= 1'b1;
         wr          <= 1'b1;
         rd          <= 1'b1;
         ad_oe       <= 1'b0;
         ad_out      <= '1;
         phase_q     <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (pop) begin
            {txn_rnw_q, txn_addr_q, txn_wdata_q} <= fifo_rdata;
         end
         ad        <= ad_d;
         cs        <= cs_d;
         wr        <= wr_d;
         rd        <= rd_d;
         ad_oe     <= oe_d;
         ad_out    <= out_d;
         phase_q   <= phase_d;
         rsp_valid <= capture;
         if (capture) rsp_rdata <= ad_in;
      end
   end

endmodule

// File: tb/tb_rtc_bus_master.sv
// tb_rtc_bus_master: directed bench for rtc_bus_master at default timing.
module tb_rtc_bus_master;

   logic       clock = 1'b0;
   logic       reset;
   logic       req_valid, req_ready, req_rnw, flush;
   logic [7:0] req_addr, req_wdata;
   logic       rsp_valid, busy, ad_oe, ad, cs, wr, rd;
   logic [7:0] rsp_rdata, ad_out, ad_in;
   logic [7:0] bus_val;

   int n_vec = 0;
   int n_err = 0;

   // {ad,cs,wr,rd,ad_oe,ad_out,rsp_valid,rsp_rdata,busy,req_ready}
   localparam logic [23:0] RST_VEC = {4'b1111, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};

   always #5 clock = ~clock;

   // RTC model: drives bus_val while rd is low.
   assign ad_in = (rd == 1'b0) ? bus_val : 8'h00;

   rtc_bus_master #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .FIFO_DEPTH (4),
      .T_ADDR     (5),
      .T_TURN     (8),
      .T_DATA     (5),
      .T_GAP      (9)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rnw   (req_rnw),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .busy      (busy),
      .ad_out    (ad_out),
      .ad_oe     (ad_oe),
      .ad_in     (ad_in),
      .ad        (ad),
      .cs        (cs),
      .wr        (wr),
      .rd        (rd)
   );

   function automatic logic [23:0] out_vec();
      return {ad, cs, wr, rd, ad_oe, ad_out, rsp_valid, rsp_rdata, busy, req_ready};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clock);
         n_vec++;
         if (out_vec() !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_hold got %h expected %h", out_vec(), RST_VEC);
         end
      end
      reset = 1'b1;
      @(negedge clock);
      n_vec++;
      if (out_vec() !== RST_VEC) begin
         n_err++;
         $display("FAIL reset_release got %h expected %h", out_vec(), RST_VEC);
      end
   endtask

   // Pins: ad low c=3, cs c=4, wr c=5..9 (addr), data wr low c=22..26.
   task automatic test_single_write();
      int first_ad = -1, first_cs = -1, first_wr = -1, first_data = -1;
      int addr_cyc = 0, data_cyc = 0, busy_cyc = 0, rd_low = 0, rsp_cnt = 0;
      @(negedge clock);
      req_valid = 1'b1; req_rnw = 1'b0; req_addr = 8'h24; req_wdata = 8'h15;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         if (c == 1) req_valid = 1'b0;
         if (!ad && first_ad < 0) first_ad = c;
         if (!cs && first_cs < 0) first_cs = c;
         if (!wr && first_wr < 0) first_wr = c;
         if (!wr && ad_oe && ad_out == 8'h24) addr_cyc++;
         if (!wr && ad_oe && ad_out == 8'h15) begin
            data_cyc++;
            if (first_data < 0) first_data = c;
         end
         if (busy) busy_cyc++;
         if (!rd) rd_low++;
         if (rsp_valid) rsp_cnt++;
      end
      n_vec++; if (first_ad !== 3)   begin n_err++; $display("FAIL wr_ad_fall got %0d expected 3", first_ad); end
      n_vec++; if (first_cs !== 4)   begin n_err++; $display("FAIL wr_cs_fall got %0d expected 4", first_cs); end
      n_vec++; if (first_wr !== 5)   begin n_err++; $display("FAIL wr_wr_fall got %0d expected 5", first_wr); end
      n_vec++; if (addr_cyc !== 5)   begin n_err++; $display("FAIL wr_addr_cycles got %0d expected 5", addr_cyc); end
      n_vec++; if (data_cyc !== 5)   begin n_err++; $display("FAIL wr_data_cycles got %0d expected 5", data_cyc); end
      n_vec++; if (first_data !== 22) begin n_err++; $display("FAIL wr_data_start got %0d expected 22", first_data); end
      n_vec++; if (busy_cyc !== 37)  begin n_err++; $display("FAIL wr_busy_cycles got %0d expected 37", busy_cyc); end
      n_vec++; if (rd_low !== 0)     begin n_err++; $display("FAIL wr_rd_low got %0d expected 0", rd_low); end
      n_vec++; if (rsp_cnt !== 0)    begin n_err++; $display("FAIL wr_rsp_pulses got %0d expected 0", rsp_cnt); end
      n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL wr_rdata_held got %h expected 00", rsp_rdata); end
   endtask

   // rd low c=22..26, rsp_valid at c=27; ad_oe only in AWR+AREL (8 cycles).
   task automatic test_read();
      int rd_low = 0, first_rd = -1, oe_cyc = 0, overlap = 0, rd_addr = 0;
      int rsp_cnt = 0, rsp_c = -1;
      logic [7:0] rsp_val = 8'h00;
      bus_val = 8'h59;
      @(negedge clock);
      req_valid = 1'b1; req_rnw = 1'b1; req_addr = 8'h21; req_wdata = 8'hAA;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         if (c == 1) req_valid = 1'b0;
         if (!rd) begin
            rd_low++;
            if (first_rd < 0) first_rd = c;
            if (!wr) overlap++;
            if (!ad) rd_addr++;
         end
         if (ad_oe) oe_cyc++;
         if (rsp_valid) begin
            rsp_cnt++;
            rsp_c   = c;
            rsp_val = rsp_rdata;
         end
      end
      n_vec++; if (rd_low !== 5)    begin n_err++; $display("FAIL rd_low_cycles got %0d expected 5", rd_low); end
      n_vec++; if (first_rd !== 22) begin n_err++; $display("FAIL rd_start got %0d expected 22", first_rd); end
      n_vec++; if (oe_cyc !== 8)    begin n_err++; $display("FAIL rd_oe_cycles got %0d expected 8", oe_cyc); end
      n_vec++; if (overlap !== 0 || rd_addr !== 0) begin
         n_err++; $display("FAIL rd_strobe_overlap got %0d/%0d expected 0/0", overlap, rd_addr);
      end
      n_vec++; if (rsp_cnt !== 1)   begin n_err++; $display("FAIL rd_rsp_pulses got %0d expected 1", rsp_cnt); end
      n_vec++; if (rsp_c !== 27)    begin n_err++; $display("FAIL rd_rsp_cycle got %0d expected 27", rsp_c); end
      n_vec++; if (rsp_val !== 8'h59) begin n_err++; $display("FAIL rd_rsp_data got %h expected 59", rsp_val); end
      n_vec++; if (rsp_rdata !== 8'h59) begin n_err++; $display("FAIL rd_rdata_hold got %h expected 59", rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_addr [6] = '{8'h24, 8'h25, 8'h26, 8'h00, 8'hF1, 8'h24};
      logic [7:0] got_addr [6];
      logic [7:0] got_data [6];
      int falls [6];
      int n_fall = 0, n_a = 0, n_d = 0, idx = 0, acc6 = -1;
      logic prev_ad = 1'b1, prev_wr = 1'b1, drv_valid = 1'b0, drv_ready = 1'b0;
      for (int c = 0; c <= 240; c++) begin
         @(negedge clock);
         if (prev_ad && !ad) begin
            if (n_fall < 6) falls[n_fall] = c;
            n_fall++;
         end
         if (prev_wr && !wr) begin
            if (!ad) begin
               if (n_a < 6) got_addr[n_a] = ad_out;
               n_a++;
            end else begin
               if (n_d < 6) got_data[n_d] = ad_out;
               n_d++;
            end
         end
         prev_ad = ad;
         prev_wr = wr;
         if (drv_valid && drv_ready) idx++;
         if (c == 5) begin
            n_vec++;
            if (req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop got %b expected 0", req_ready); end
         end
         if (idx < 6) begin
            req_valid = 1'b1; req_rnw = 1'b0;
            req_addr  = exp_addr[idx];
            req_wdata = 8'h31 + 8'(idx);
            drv_valid = 1'b1;
            drv_ready = req_ready;
            if (idx == 5 && req_ready && acc6 < 0) acc6 = c;
         end else begin
            req_valid = 1'b0;
            drv_valid = 1'b0;
         end
      end
      n_vec++; if (acc6 !== 38)  begin n_err++; $display("FAIL b2b_sixth_accept got %0d expected 38", acc6); end
      n_vec++; if (n_fall !== 6 || n_a !== 6 || n_d !== 6) begin
         n_err++; $display("FAIL b2b_txn_count got %0d/%0d/%0d expected 6/6/6", n_fall, n_a, n_d);
      end
      if (n_fall == 6 && n_a == 6 && n_d == 6) begin
         for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== 8'h31 + 8'(i)) begin
               n_err++;
               $display("FAIL b2b_order[%0d] got %h/%h expected %h/%h", i, got_addr[i], got_data[i], exp_addr[i], 8'h31 + 8'(i));
            end
            n_vec++;
            if (falls[i] !== 3 + 36 * i) begin
               n_err++; $display("FAIL b2b_spacing[%0d] got %0d expected %0d", i, falls[i], 3 + 36 * i);
            end
         end
      end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_busy got %b expected 0", busy); end
   endtask

   task automatic test_flush();
      int n_fall = 0, first_idle = -1, data_cyc = 0;
      logic prev_ad = 1'b1;
      for (int c = 0; c <= 80; c++) begin
         @(negedge clock);
         if (prev_ad && !ad) n_fall++;
         prev_ad = ad;
         if (!wr && ad && ad_out == 8'h50) data_cyc++;
         if (!busy && first_idle < 0 && c > 0) first_idle = c;
         if (c == 37) begin
            n_vec++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL fl_busy_gap got %b expected 1", busy); end
         end
         flush = 1'b0;
         req_valid = 1'b0;
         if (c <= 3) begin
            req_valid = 1'b1; req_rnw = 1'b0;
            req_addr = 8'h24 + 8'(c); req_wdata = 8'h50 + 8'(c);
         end else if (c == 5) begin
            // Push offered together with flush must be dropped.
            flush = 1'b1;
            req_valid = 1'b1; req_rnw = 1'b0; req_addr = 8'hF1; req_wdata = 8'h77;
         end
      end
      n_vec++; if (n_fall !== 1)     begin n_err++; $display("FAIL fl_txn_count got %0d expected 1", n_fall); end
      n_vec++; if (data_cyc !== 5)   begin n_err++; $display("FAIL fl_inflight_data got %0d expected 5", data_cyc); end
      n_vec++; if (first_idle !== 38) begin n_err++; $display("FAIL fl_busy_fall got %0d expected 38", first_idle); end
   endtask

   task automatic test_reset_mid();
      int rsp_cnt = 0, ad_low = 0, busy_cyc = 0, rd_low = 0;
      logic [7:0] rsp_val = 8'h00;
      bus_val = 8'hC3;
      @(negedge clock);
      req_valid = 1'b1; req_rnw = 1'b1; req_addr = 8'h26; req_wdata = 8'h00;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clock);
         req_valid = 1'b0;
      end
      n_vec++; if (rd !== 1'b0) begin n_err++; $display("FAIL mid_in_dstb got rd=%b expected 0", rd); end
      #2 reset = 1'b0;
      #1;
      n_vec++;
      if (out_vec() !== RST_VEC) begin
         n_err++; $display("FAIL mid_async_reset got %h expected %h", out_vec(), RST_VEC);
      end
      @(negedge clock);
      reset = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (rsp_valid) rsp_cnt++;
         if (!ad) ad_low++;
         if (busy) busy_cyc++;
      end
      n_vec++; if (rsp_cnt !== 0 || ad_low !== 0 || busy_cyc !== 0) begin
         n_err++; $display("FAIL mid_quiet got %0d/%0d/%0d expected 0/0/0", rsp_cnt, ad_low, busy_cyc);
      end
      bus_val = 8'hA7;
      rsp_cnt = 0;
      @(negedge clock);
      req_valid = 1'b1; req_rnw = 1'b1; req_addr = 8'h25;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clock);
         req_valid = 1'b0;
         if (!rd) rd_low++;
         if (rsp_valid) begin
            rsp_cnt++;
            rsp_val = rsp_rdata;
         end
      end
      n_vec++; if (rd_low !== 5 || rsp_cnt !== 1 || rsp_val !== 8'hA7) begin
         n_err++; $display("FAIL mid_recover got rd_low=%0d rsp=%0d data=%h expected 5/1/a7", rd_low, rsp_cnt, rsp_val);
      end
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_rnw = 1'b0; flush = 1'b0;
      req_addr = 8'h00; req_wdata = 8'h00; bus_val = 8'h00;
      test_reset();
      test_single_write();
      test_read();
      test_back_to_back();
      repeat (3) @(negedge clock);
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
